// File: rtl/ofifo_drain_ctrl.sv
// ofifo_drain_ctrl: drains the column output FIFO bank into the psum SRAM.
// Build option: OFIFO_DRAIN_RELU_EN clamps negative column fields to zero.
module ofifo_drain_ctrl #(
  parameter int col    = 8,
  parameter int bw     = 4,
  parameter int AW     = 11,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AW:0]       num_rows,
  input  logic [AW-1:0]     base_addr,
  output logic              busy,
  output logic              done,
  input  logic              ofifo_valid,
  output logic              ofifo_rd,
  input  logic [col*bw-1:0] ofifo_out,
  output logic              mem_wr,
  output logic [AW-1:0]     mem_addr,
  output logic [col*bw-1:0] mem_din,
  input  logic              mem_ready
);

  localparam int DW = col * bw;

  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 1);
  localparam logic [AW:0] LAST_ROW = (AW + 1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    POP,
    SETTLE_ST,
    WRITE,
    DONE
  } state_t;

  state_t            state;
  logic [AW:0]       remaining;
  logic [AW-1:0]     addr_q;
  logic [2:0]        settle_cnt;
  logic [DW-1:0]     data_q;

  // Row shaping applied at capture time; identity unless ReLU is built in.
  function automatic logic [DW-1:0] shape_row(input logic [DW-1:0] row);
    logic [DW-1:0] r;
    r = row;
`ifdef OFIFO_DRAIN_RELU_EN
    for (int i = 0; i < col; i++) begin
      if (row[i*bw+bw-1]) r[i*bw +: bw] = '0;
    end
`else
`endif
    return r;
  endfunction

  // Drain sequencer: wait for a full row, pop it, let the bank settle,
  // then hold the SRAM write until it is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      ofifo_rd   <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      remaining  <= '0;
      addr_q     <= '0;
      settle_cnt <= '0;
      data_q     <= '0;
    end else begin
      ofifo_rd <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        IDLE: begin
          // done is high here for one cycle; a start alongside it is dropped
          if (start && !done) begin
            if (num_rows == '0) begin
              state <= DONE;
            end else begin
              remaining <= num_rows;
              addr_q    <= base_addr;
              busy      <= 1'b1;
              state     <= WAIT;
            end
          end
        end
        WAIT: begin
          if (ofifo_valid) begin
            ofifo_rd <= 1'b1;
            state    <= POP;
          end
        end
        POP: begin
          // head row is still presented while the pop strobe is high
          data_q     <= shape_row(ofifo_out);
          settle_cnt <= '0;
          state      <= SETTLE_ST;
        end
        SETTLE_ST: begin
          if (settle_cnt == SETTLE_LAST) begin
            mem_wr   <= 1'b1;
            mem_addr <= addr_q;
            mem_din  <= data_q;
            state    <= WRITE;
          end else begin
            settle_cnt <= settle_cnt + 3'd1;
          end
        end
        WRITE: begin
          if (mem_ready) begin
            mem_wr    <= 1'b0;
            addr_q    <= addr_q + 1'b1;
            remaining <= remaining - 1'b1;
            state     <= (remaining == LAST_ROW) ? DONE : WAIT;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// tb_ofifo_drain_ctrl: scoreboard bench for the output FIFO drain sequencer.
// Writes are queued at stimulus time and checked by an independent monitor.
module tb_ofifo_drain_ctrl;

  localparam int AW = 11;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   num_rows;
  logic [AW-1:0] base_addr;
  logic          busy;
  logic          done;
  logic          ofifo_valid;
  logic          ofifo_rd;
  logic [DW-1:0] ofifo_out;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_ready;

  ofifo_drain_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_rows    (num_rows),
    .base_addr   (base_addr),
    .busy        (busy),
    .done        (done),
    .ofifo_valid (ofifo_valid),
    .ofifo_rd    (ofifo_rd),
    .ofifo_out   (ofifo_out),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_ready   (mem_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO bank model
  logic [DW-1:0] fifo_mem [0:15];
  logic [4:0]    wr_ptr = '0;
  logic [4:0]    rd_ptr = '0;
  logic          valid_en = 1'b0;

  assign ofifo_out   = fifo_mem[rd_ptr[3:0]];
  assign ofifo_valid = valid_en && (wr_ptr != rd_ptr);

  always @(posedge clk)
    if (ofifo_rd && (wr_ptr != rd_ptr)) rd_ptr <= rd_ptr + 5'd1;

  logic [AW+DW-1:0] exp_q[$];
  int               rd_times[$];
  int               done_seen = 0;
  logic             prev_rd = 1'b0;
  logic             hold_prev = 1'b0;
  logic [AW-1:0]    prev_addr = '0;
  logic [DW-1:0]    prev_din = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard on every accepted write.
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (!reset) begin
      if (ofifo_rd) begin
        chk("rd_spacing", prev_rd, 0);
        chk("rd_nonempty", (wr_ptr != rd_ptr), 1);
        rd_times.push_back(cyc);
      end
      if (hold_prev) begin
        chk("hold_wr", mem_wr, 1);
        chk("hold_addr", mem_addr, prev_addr);
        chk("hold_din", mem_din, prev_din);
      end
      if (mem_wr && mem_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0h data %0h",
                   mem_addr, mem_din);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", mem_addr, e[AW+DW-1:DW]);
          chk("wr_data", mem_din, e[DW-1:0]);
        end
      end
      if (done) done_seen++;
    end
    prev_rd   = ofifo_rd;
    prev_addr = mem_addr;
    prev_din  = mem_din;
    hold_prev = !reset && mem_wr && !mem_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input logic [DW-1:0] r);
    fifo_mem[wr_ptr[3:0]] = r;
    wr_ptr = wr_ptr + 5'd1;
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic do_start(input logic [AW:0] n, input logic [AW-1:0] b);
    num_rows  = n;
    base_addr = b;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (!done && k < 300) begin
      tick();
      k++;
    end
    chk(nm, done, 1);
  endtask

  task automatic wait_wr(input logic want, input string nm);
    int k = 0;
    while (mem_wr !== want && k < 100) begin
      tick();
      k++;
    end
    chk(nm, mem_wr, want);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    int d;
    int n_rd;
    reset     = 1'b1;
    start     = 1'b0;
    num_rows  = '0;
    base_addr = '0;
    mem_ready = 1'b1;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd", ofifo_rd, 0);
    chk("rst_wr", mem_wr, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_din", mem_din, 0);
    reset = 1'b0;
    tick();

    // zero rows: done two cycles after start, nothing else moves
    c = cyc;
    do_start(0, 11'h055);
    chk("z_done_early", done, 0);
    chk("z_busy1", busy, 0);
    tick();
    chk("z_done_cyc", cyc, c + 2);
    chk("z_done", done, 1);
    chk("z_busy2", busy, 0);
    chk("z_no_rd", rd_times.size(), 0);
    chk("z_no_wr", mem_wr, 0);
    tick();

    // four rows back to back
    push_row(32'h0123_4567);
    push_row(32'h7654_3210);
    push_row(32'h1234_5670);
    push_row(32'h0707_0707);
    expect_wr(11'h010, 32'h0123_4567);
    expect_wr(11'h011, 32'h7654_3210);
    expect_wr(11'h012, 32'h1234_5670);
    expect_wr(11'h013, 32'h0707_0707);
    valid_en = 1'b1;
    rd_times.delete();
    c = cyc;
    do_start(4, 11'h010);
    chk("b_busy", busy, 1);
    wait_done("b_done");
    chk("b_done_cyc", cyc, c + 22);
    chk("b_rd_count", rd_times.size(), 4);
    chk("b_first_rd", rd_times[0], c + 2);
    for (int i = 1; i < rd_times.size(); i++)
      chk("b_rd_gap", rd_times[i] - rd_times[i-1], 5);
    tick();
    chk("b_busy_off", busy, 0);

    // FIFO not ready for 20 cycles
    push_row(32'h3333_3333);
    expect_wr(11'h100, 32'h3333_3333);
    valid_en = 1'b0;
    rd_times.delete();
    do_start(1, 11'h100);
    repeat (20) tick();
    chk("v_no_rd", rd_times.size(), 0);
    chk("v_busy", busy, 1);
    d = cyc;
    valid_en = 1'b1;
    wait_done("v_done");
    chk("v_rd_count", rd_times.size(), 1);
    chk("v_first_rd", rd_times[0], d + 1);
    tick();

    // SRAM stalls 6 cycles on row 2
    push_row(32'h1010_1010);
    push_row(32'h2020_2020);
    push_row(32'h3030_3030);
    expect_wr(11'h020, 32'h1010_1010);
    expect_wr(11'h021, 32'h2020_2020);
    expect_wr(11'h022, 32'h3030_3030);
    rd_times.delete();
    do_start(3, 11'h020);
    wait_wr(1'b1, "s_wr1");
    wait_wr(1'b0, "s_wr1_drop");
    mem_ready = 1'b0;
    wait_wr(1'b1, "s_wr2");
    n_rd = rd_times.size();
    repeat (6) tick();
    chk("s_no_extra_pop", rd_times.size(), n_rd);
    chk("s_wr_held", mem_wr, 1);
    chk("s_addr_held", mem_addr, 11'h021);
    mem_ready = 1'b1;
    wait_done("s_done");
    chk("s_rd_count", rd_times.size(), 3);
    tick();

    // address wrap
    push_row(32'h8F17_00A3);
    push_row(32'h4444_0000);
`ifdef OFIFO_DRAIN_RELU_EN
    expect_wr(11'h7FF, 32'h0017_0003);
`else
    expect_wr(11'h7FF, 32'h8F17_00A3);
`endif
    expect_wr(11'h000, 32'h4444_0000);
    do_start(2, 11'h7FF);
    wait_done("w_done");
    tick();

    // reset while a write is stalled
    push_row(32'h5555_5555);
    push_row(32'h6666_6666);
    mem_ready = 1'b0;
    do_start(2, 11'h300);
    wait_wr(1'b1, "r_wr");
    tick();
    reset = 1'b1;
    tick();
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    chk("r_rd", ofifo_rd, 0);
    chk("r_wr0", mem_wr, 0);
    chk("r_addr", mem_addr, 0);
    chk("r_din", mem_din, 0);
    reset     = 1'b0;
    valid_en  = 1'b0;
    mem_ready = 1'b1;
    repeat (10) tick();
    chk("r_no_done", done_seen, 5);
    chk("r_idle", busy, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
